// File: rtl/cla_16_lca.sv
// -----------------------------------------------------------------------------
// cla_16_lca
//   16-bit unsigned adder built from four 4-bit carry-lookahead slices and a
//   4-bit lookahead carry unit. The sum, carry-out and group propagate /
//   generate are registered so the block can be cascaded into a wider
//   lookahead adder (p/g feed the next LCU level).
//
//   Ports
//     clk   in   1   system clock, all outputs update on its rising edge
//     rst   in   1   synchronous active-high reset, clears every output
//     A     in   16  addend A, unsigned
//     B     in   16  addend B, unsigned
//     cin   in   1   carry into bit 0
//     sum   out  16  registered (A + B + cin) mod 2^16
//     cout  out  1   registered carry out of bit 15
//     p     out  1   registered group propagate, &(A ^ B)
//     g     out  1   registered group generate (carry-independent carry out)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// cla_16_lca_slice
//   4-bit carry-lookahead slice. Every internal carry is a flat sum of
//   products of the slice carry-in, so no carry ripples between bits.
//
//   Ports
//     a, b  in   4   operand bits of this slice
//     c0    in   1   carry into the slice (from the LCU)
//     s     out  4   slice sum bits
//     pg    out  1   slice group propagate
//     gg    out  1   slice group generate
// -----------------------------------------------------------------------------
module cla_16_lca_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c0,
   output logic [3:0] s,
   output logic       pg,
   output logic       gg
);

   logic [3:0] pb;
   logic [3:0] gb;
   logic [3:0] c;

   always_comb begin
      pb = a ^ b;
      gb = a & b;

      c[0] = c0;
      c[1] = gb[0]
           | (pb[0] & c0);
      c[2] = gb[1]
           | (pb[1] & gb[0])
           | (pb[1] & pb[0] & c0);
      c[3] = gb[2]
           | (pb[2] & gb[1])
           | (pb[2] & pb[1] & gb[0])
           | (pb[2] & pb[1] & pb[0] & c0);

      s = pb ^ c;

      pg = &pb;
      gg = gb[3]
         | (pb[3] & gb[2])
         | (pb[3] & pb[2] & gb[1])
         | (pb[3] & pb[2] & pb[1] & gb[0]);
   end

endmodule

// -----------------------------------------------------------------------------
// cla_16_lca_lcu
//   4-bit lookahead carry unit. Each slice carry is a flattened
//   sum-of-products of the slice P/G terms and cin rather than a chain
//   through the previous slice carry.
//
//   Ports
//     pk    in   4   slice group propagates (index = slice number)
//     gk    in   4   slice group generates
//     cin   in   1   carry into slice 0
//     c     out  4   carries into slices 0..3 (c[0] is cin)
//     c16   out  1   carry out of the top slice
//     pgrp  out  1   16-bit group propagate
//     ggrp  out  1   16-bit group generate
// -----------------------------------------------------------------------------
module cla_16_lca_lcu (
   input  logic [3:0] pk,
   input  logic [3:0] gk,
   input  logic       cin,
   output logic [3:0] c,
   output logic       c16,
   output logic       pgrp,
   output logic       ggrp
);

   always_comb begin
      c[0] = cin;
      c[1] = gk[0]
           | (pk[0] & cin);
      c[2] = gk[1]
           | (pk[1] & gk[0])
           | (pk[1] & pk[0] & cin);
      c[3] = gk[2]
           | (pk[2] & gk[1])
           | (pk[2] & pk[1] & gk[0])
           | (pk[2] & pk[1] & pk[0] & cin);
      c16  = gk[3]
           | (pk[3] & gk[2])
           | (pk[3] & pk[2] & gk[1])
           | (pk[3] & pk[2] & pk[1] & gk[0])
           | (pk[3] & pk[2] & pk[1] & pk[0] & cin);

      pgrp = &pk;
      ggrp = gk[3]
           | (pk[3] & gk[2])
           | (pk[3] & pk[2] & gk[1])
           | (pk[3] & pk[2] & pk[1] & gk[0]);
   end

endmodule

// -----------------------------------------------------------------------------
// Top level: four slices, one LCU, output register.
// -----------------------------------------------------------------------------
module cla_16_lca (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout,
   output logic        p,
   output logic        g
);

   logic [3:0]  pk;
   logic [3:0]  gk;
   logic [3:0]  cs;
   logic [15:0] sum_c;
   logic        c16;
   logic        pgrp;
   logic        ggrp;

   for (genvar k = 0; k < 4; k++) begin : g_slice
      cla_16_lca_slice u_slice (
         .a  (A[4*k +: 4]),
         .b  (B[4*k +: 4]),
         .c0 (cs[k]),
         .s  (sum_c[4*k +: 4]),
         .pg (pk[k]),
         .gg (gk[k])
      );
   end

   cla_16_lca_lcu u_lcu (
      .pk   (pk),
      .gk   (gk),
      .cin  (cin),
      .c    (cs),
      .c16  (c16),
      .pgrp (pgrp),
      .ggrp (ggrp)
   );

   // Reset wins over the operands sampled at the same edge, so a result
   // in flight when rst is asserted is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum  <= '0;
         cout <= 1'b0;
         p    <= 1'b0;
         g    <= 1'b0;
      end else begin
         sum  <= sum_c;
         cout <= c16;
         p    <= pgrp;
         g    <= ggrp;
      end
   end

endmodule

// File: tb/tb_cla_16_lca.sv
// -----------------------------------------------------------------------------
// tb_cla_16_lca
//   Scoreboard bench for cla_16_lca. The stimulus process drives operands on
//   the falling edge and, at the rising edge that captures them, pushes the
//   expected registered outputs into a queue. The monitor pops one entry at
//   each following falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_cla_16_lca;

   logic        clk;
   logic        rst;
   logic [15:0] A;
   logic [15:0] B;
   logic        cin;
   logic [15:0] sum;
   logic        cout;
   logic        p;
   logic        g;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        p;
      logic        g;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   int unsigned checks;
   int unsigned errors;
   bit          stim_done;

   cla_16_lca dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .p    (p),
      .g    (g)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference group terms: p is all-propagate, g is the carry out with cin=0.
   function automatic logic model_p(input logic [15:0] a, input logic [15:0] b);
      return &(a ^ b);
   endfunction

   function automatic logic model_g(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] t;
      t = {1'b0, a} + {1'b0, b};
      return t[16];
   endfunction

   // Drive one cycle of stimulus and push its expected result at the capture edge.
   task automatic issue(input logic r, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es, input logic ec,
                        input logic ep, input logic eg, input string nm);
      exp_t e;
      @(negedge clk);
      rst = r;
      A   = a;
      B   = b;
      cin = c;
      @(posedge clk);
      e.sum  = es;
      e.cout = ec;
      e.p    = ep;
      e.g    = eg;
      e.name = nm;
      exp_q.push_back(e);
   endtask

   // Directed vector: sum/cout hand-computed, p/g from the reference functions.
   task automatic dvec(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input logic [15:0] es, input logic ec, input string nm);
      issue(1'b0, a, b, c, es, ec, model_p(a, b), model_g(a, b), nm);
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (sum !== e.sum) begin
               errors++;
               $display("FAIL %s sum: got %0d expected %0d", e.name, sum, e.sum);
            end
            checks++;
            if (cout !== e.cout) begin
               errors++;
               $display("FAIL %s cout: got %b expected %b", e.name, cout, e.cout);
            end
            checks++;
            if (p !== e.p) begin
               errors++;
               $display("FAIL %s p: got %b expected %b", e.name, p, e.p);
            end
            checks++;
            if (g !== e.g) begin
               errors++;
               $display("FAIL %s g: got %b expected %b", e.name, g, e.g);
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rc;
      logic [16:0] full;
      checks    = 0;
      errors    = 0;
      stim_done = 1'b0;
      rst = 1'b1;
      A   = '0;
      B   = '0;
      cin = 1'b0;

      // Reset held with live operands: outputs stay zero.
      for (int i = 0; i < 3; i++)
         issue(1'b1, 16'd65000, 16'd65340, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, "reset_hold");
      // First result one edge after rst falls.
      dvec(16'd65000, 16'd65340, 1'b0, 16'd64804, 1'b1, "post_reset");

      dvec(16'd58135, 16'd3592,  1'b0, 16'd61727, 1'b0, "vec_58135_3592");
      dvec(16'd50,    16'd10024, 1'b0, 16'd10074, 1'b0, "vec_50_10024");
      dvec(16'd1005,  16'd69,    1'b1, 16'd1075,  1'b0, "vec_1005_69_c1");
      dvec(16'd15124, 16'd5383,  1'b1, 16'd20508, 1'b0, "vec_15124_5383_c1");
      issue(1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, "allprop_c1");
      issue(1'b0, 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, "allprop_c0");
      issue(1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "msb_gen");
      issue(1'b0, 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, "cross_c4");
      issue(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, "max_c1");
      issue(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, "cross_c8");
      issue(1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, "cross_c12");
      issue(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, "zero");

      // Mid-stream reset pulse discards that cycle's result.
      dvec(16'd1000, 16'd2000, 1'b0, 16'd3000, 1'b0, "pre_pulse");
      issue(1'b1, 16'd65000, 16'd65340, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, "rst_pulse");
      dvec(16'd4660, 16'd22136, 1'b1, 16'd26797, 1'b0, "post_pulse");

      // Random vectors against the behavioural sum.
      for (int i = 0; i < 10000; i++) begin
         ra   = 16'($urandom);
         rb   = 16'($urandom);
         rc   = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
         issue(1'b0, ra, rb, rc, full[15:0], full[16], model_p(ra, rb), model_g(ra, rb), "random");
      end

      stim_done = 1'b1;
      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++)
         @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time bound on the whole run.
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks);
      $fatal(1);
   end

endmodule
